id_ex_pipe_reg: RTL

- Parametrised ID→EX pipeline register for the MIPS pipeline, with a valid bit, hold on stall and bubble insertion on flush.
- Carries register-file operands, register indices, funct, immediate and the full EX/MEM/WB control bundle.
- Two saturating performance counters count stall-held and bubble cycles for debug readout.
- Sits between the decode stage and the ALU/forwarding logic; stall and flush come from the hazard unit.

---
 rtl/id_ex_pkg.sv | 31 +++
 rtl/id_ex_pipe_reg_sat_counter.sv | 40 ++++
 rtl/id_ex_pipe_reg.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/id_ex_pkg.sv
// Shared definitions for the ID->EX pipeline register: control-bundle layout,
// bit offsets and the bubble constant.
package id_ex_pkg;

    localparam int CTRL_W = 16;

    localparam int OFF_MEMTOREG = 15;
    localparam int OFF_MEMREAD  = 14;
    localparam int OFF_MEMWRITE = 13;
    localparam int OFF_ALUSRC   = 12;
    localparam int OFF_LINK     = 11;
    localparam int OFF_REGWRITE = 10;
    localparam int OFF_ALUOP    = 7;
    localparam int OFF_REGDST   = 5;
    localparam int OFF_SIZECTL  = 0;

    typedef struct packed {
        logic       memtoreg;
        logic       memread;
        logic       memwrite;
        logic       alusource;
        logic       link;
        logic       regwrite;
        logic [2:0] aluop;
        logic [1:0] regdst;
        logic [4:0] sizecontrol;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = ctrl_t'(16'h0000);

endpackage

// File: rtl/id_ex_pipe_reg_sat_counter.sv
// Saturating event counter with asynchronous reset and synchronous clear.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);

    localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

    logic [W-1:0] cnt_r;
    logic [W-1:0] cnt_nxt_s;

    // Next count: clear dominates, increment stops at the maximum.
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (i_clr) begin
            cnt_nxt_s = {W{1'b0}};
        end else if (i_inc && (cnt_r != CNT_MAX)) begin
            cnt_nxt_s = cnt_r + {{(W-1){1'b0}}, 1'b1};
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Counter register.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            cnt_r <= {W{1'b0}};
        end else begin
            cnt_r <= cnt_nxt_s;
        end
    end

    assign o_cnt = cnt_r;

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID->EX pipeline register with valid bit, stall hold, flush bubble and
// saturating stall/bubble debug counters.
module id_ex_pipe_reg
    import id_ex_pkg::*;
#(
    parameter int NBITS      = 32,
    parameter int RBITS      = 5,
    parameter int FBITS      = 6,
    parameter int CBITS      = 16,
    parameter bit FLUSH_DATA = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             stallID,
    input  logic             flushID,
    input  logic             i_cnt_clr,
    input  logic             ID_valid,
    input  logic [NBITS-1:0] ID_Rs,
    input  logic [NBITS-1:0] ID_Rt,
    input  logic [RBITS-1:0] ID_rd,
    input  logic [RBITS-1:0] ID_rt,
    input  logic [FBITS-1:0] ID_funct,
    input  logic [NBITS-1:0] ID_immediate,
    input  logic             ID_memtoreg,
    input  logic             ID_memread,
    input  logic             ID_memwrite,
    input  logic             ID_alusource,
    input  logic             ID_link,
    input  logic             ID_regwrite,
    input  logic [2:0]       ID_aluop,
    input  logic [1:0]       ID_regdst,
    input  logic [4:0]       ID_sizecontrol,
    output logic             EX_valid,
    output logic [NBITS-1:0] EX_Rs,
    output logic [NBITS-1:0] EX_Rt,
    output logic [RBITS-1:0] EX_rd,
    output logic [RBITS-1:0] EX_rt,
    output logic [FBITS-1:0] EX_funct,
    output logic [NBITS-1:0] EX_immediate,
    output logic             EX_memtoreg,
    output logic             EX_memread,
    output logic             EX_memwrite,
    output logic             EX_alusource,
    output logic             EX_link,
    output logic             EX_regwrite,
    output logic [2:0]       EX_aluop,
    output logic [1:0]       EX_regdst,
    output logic [4:0]       EX_sizecontrol,
    output logic [CBITS-1:0] o_stall_cnt,
    output logic [CBITS-1:0] o_bubble_cnt
);

    ctrl_t             ctrl_in_s, ctrl_r, ctrl_nxt_s;
    logic              valid_r, valid_nxt_s;
    logic [NBITS-1:0]  rs_r, rs_nxt_s, rt_val_r, rt_val_nxt_s, imm_r, imm_nxt_s;
    logic [RBITS-1:0]  rd_r, rd_nxt_s, rt_idx_r, rt_idx_nxt_s;
    logic [FBITS-1:0]  funct_r, funct_nxt_s;
    logic              stall_inc_s, bubble_inc_s;

    assign ctrl_in_s = '{memtoreg: ID_memtoreg, memread: ID_memread, memwrite: ID_memwrite,
                         alusource: ID_alusource, link: ID_link, regwrite: ID_regwrite,
                         aluop: ID_aluop, regdst: ID_regdst, sizecontrol: ID_sizecontrol};

    // Next-state selection: flush over stall over load.
    always_comb begin
        valid_nxt_s  = valid_r;
        ctrl_nxt_s   = ctrl_r;
        rs_nxt_s     = rs_r;
        rt_val_nxt_s = rt_val_r;
        rd_nxt_s     = rd_r;
        rt_idx_nxt_s = rt_idx_r;
        funct_nxt_s  = funct_r;
        imm_nxt_s    = imm_r;
        if (flushID) begin
            valid_nxt_s = 1'b0;
            ctrl_nxt_s  = CTRL_NOP;
            if (FLUSH_DATA) begin
                rs_nxt_s     = {NBITS{1'b0}};
                rt_val_nxt_s = {NBITS{1'b0}};
                rd_nxt_s     = {RBITS{1'b0}};
                rt_idx_nxt_s = {RBITS{1'b0}};
                funct_nxt_s  = {FBITS{1'b0}};
                imm_nxt_s    = {NBITS{1'b0}};
            end else begin
                rs_nxt_s = rs_r;
            end
        end else if (stallID) begin
            valid_nxt_s = valid_r;
        end else begin
            // An invalid slot never carries live control bits.
            valid_nxt_s  = ID_valid;
            ctrl_nxt_s   = ID_valid ? ctrl_in_s : CTRL_NOP;
            rs_nxt_s     = ID_Rs;
            rt_val_nxt_s = ID_Rt;
            rd_nxt_s     = ID_rd;
            rt_idx_nxt_s = ID_rt;
            funct_nxt_s  = ID_funct;
            imm_nxt_s    = ID_immediate;
        end
    end

    // Pipeline register bank.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            valid_r  <= 1'b0;
            ctrl_r   <= CTRL_NOP;
            rs_r     <= {NBITS{1'b0}};
            rt_val_r <= {NBITS{1'b0}};
            rd_r     <= {RBITS{1'b0}};
            rt_idx_r <= {RBITS{1'b0}};
            funct_r  <= {FBITS{1'b0}};
            imm_r    <= {NBITS{1'b0}};
        end else begin
            valid_r  <= valid_nxt_s;
            ctrl_r   <= ctrl_nxt_s;
            rs_r     <= rs_nxt_s;
            rt_val_r <= rt_val_nxt_s;
            rd_r     <= rd_nxt_s;
            rt_idx_r <= rt_idx_nxt_s;
            funct_r  <= funct_nxt_s;
            imm_r    <= imm_nxt_s;
        end
    end

    assign stall_inc_s  = stallID & ~flushID & valid_r;
    assign bubble_inc_s = flushID | (~stallID & ~ID_valid);

    sat_counter #(.W(CBITS)) u_stall_cnt (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (i_cnt_clr),
        .i_inc (stall_inc_s),
        .o_cnt (o_stall_cnt)
    );

    sat_counter #(.W(CBITS)) u_bubble_cnt (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (i_cnt_clr),
        .i_inc (bubble_inc_s),
        .o_cnt (o_bubble_cnt)
    );

    assign EX_valid       = valid_r;
    assign EX_Rs          = rs_r;
    assign EX_Rt          = rt_val_r;
    assign EX_rd          = rd_r;
    assign EX_rt          = rt_idx_r;
    assign EX_funct       = funct_r;
    assign EX_immediate   = imm_r;
    assign EX_memtoreg    = ctrl_r.memtoreg;
    assign EX_memread     = ctrl_r.memread;
    assign EX_memwrite    = ctrl_r.memwrite;
    assign EX_alusource   = ctrl_r.alusource;
    assign EX_link        = ctrl_r.link;
    assign EX_regwrite    = ctrl_r.regwrite;
    assign EX_aluop       = ctrl_r.aluop;
    assign EX_regdst      = ctrl_r.regdst;
    assign EX_sizecontrol = ctrl_r.sizecontrol;

endmodule
